// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - Shared constants for the memory access controller
package mem_access_ctrl_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W      = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SETUP  = 3'd1;
  localparam state_t ST_STROBE = 3'd2;
  localparam state_t ST_HOLD   = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

endpackage

// File: rtl/mem_wait_counter.sv
// rtl/mem_wait_counter.sv - Loadable down-counter sizing the strobe phase
module mem_wait_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - Arbitrating bus initiator for the 16x8 asynchronous memory
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ack,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_ack,
  output logic [DATA_W-1:0] data_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
);

  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
  logic              fetch_ack_q, fetch_ack_d;
  logic              data_ack_q, data_ack_d;
  logic [DATA_W-1:0] fetch_rdata_q, fetch_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
  logic              busy_q, busy_d;
  logic              cnt_load;
  logic              cnt_en;
  logic              cnt_tc;

  mem_wait_counter #(
    .WIDTH (CNT_W)
  ) u_wait_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (STROBE_LAST),
    .en_i       (cnt_en),
    .tc_o       (cnt_tc)
  );

  // Address and data are latched straight into the bus registers, so they stay
  // frozen from SETUP through HOLD regardless of what the requester does.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    we_d          = we_q;
    mem_address_d = mem_address_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_data_in_d = mem_data_in_q;
    fetch_rdata_d = fetch_rdata_q;
    data_rdata_d  = data_rdata_q;
    fetch_ack_d   = 1'b0;
    data_ack_d    = 1'b0;
    cnt_load      = 1'b0;
    cnt_en        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (data_req) begin
          grant_d       = GRANT_DATA;
          we_d          = data_we;
          mem_address_d = data_addr;
          mem_data_in_d = data_we ? data_wdata : '0;
          state_d       = ST_SETUP;
        end else if (fetch_req) begin
          grant_d       = GRANT_FETCH;
          we_d          = 1'b0;
          mem_address_d = fetch_addr;
          mem_data_in_d = '0;
          state_d       = ST_SETUP;
        end
      end
      ST_SETUP: begin
        mem_read_d  = ~we_q;
        mem_write_d = we_q;
        cnt_load    = 1'b1;
        state_d     = ST_STROBE;
      end
      ST_STROBE: begin
        if (cnt_tc) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (!we_q) begin
            if (grant_q == GRANT_DATA) begin
              data_rdata_d = mem_data_out;
            end else begin
              fetch_rdata_d = mem_data_out;
            end
          end
          state_d = ST_HOLD;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_HOLD: begin
        mem_address_d = '0;
        mem_data_in_d = '0;
        fetch_ack_d   = (grant_q == GRANT_FETCH);
        data_ack_d    = (grant_q == GRANT_DATA);
        state_d       = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        mem_address_d = '0;
        mem_data_in_d = '0;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        state_d       = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= GRANT_FETCH;
      we_q          <= 1'b0;
      mem_address_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_data_in_q <= '0;
      fetch_ack_q   <= 1'b0;
      data_ack_q    <= 1'b0;
      fetch_rdata_q <= '0;
      data_rdata_q  <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      we_q          <= we_d;
      mem_address_q <= mem_address_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_data_in_q <= mem_data_in_d;
      fetch_ack_q   <= fetch_ack_d;
      data_ack_q    <= data_ack_d;
      fetch_rdata_q <= fetch_rdata_d;
      data_rdata_q  <= data_rdata_d;
      busy_q        <= busy_d;
    end
  end

  assign mem_address = mem_address_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_data_in = mem_data_in_q;
  assign fetch_ack   = fetch_ack_q;
  assign data_ack    = data_ack_q;
  assign fetch_rdata = fetch_rdata_q;
  assign data_rdata  = data_rdata_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - Scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;

  localparam int W1 = 1;
  localparam int W3 = 3;
  localparam logic [7:0] INIT [16] = '{8'h4C, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                                       8'h88, 8'h99, 8'h08, 8'hBB, 8'h0E, 8'hDD, 8'hEE, 8'hF0};

  typedef struct {
    bit         is_data;
    bit         is_read;
    bit         check_data;
    logic [7:0] exp;
    int         issue;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic       fetch_req = 1'b0, data_req = 1'b0, data_we = 1'b0;
  logic [3:0] fetch_addr = '0, data_addr = '0;
  logic [7:0] data_wdata = '0;
  logic       fetch_ack, data_ack, mem_read, mem_write, busy;
  logic [7:0] fetch_rdata, data_rdata, mem_data_in, mem_data_out;
  logic [3:0] mem_address;
  logic [7:0] dut_mem [16];

  mem_access_ctrl #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(W1)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_rdata(fetch_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ack(data_ack), .data_rdata(data_rdata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
  );

  assign mem_data_out = dut_mem[mem_address];
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 16; i++) dut_mem[i] <= INIT[i];
    end else if (mem_write) begin
      dut_mem[mem_address] <= mem_data_in;
    end
  end

  logic       d3_fetch_req = 1'b0, d3_data_req = 1'b0;
  logic [3:0] d3_fetch_addr = '0, d3_data_addr = '0;
  logic       d3_fetch_ack, d3_data_ack, d3_mem_read, d3_mem_write, d3_busy;
  logic [7:0] d3_fetch_rdata, d3_data_rdata, d3_mem_data_in, d3_mem_data_out;
  logic [3:0] d3_mem_address;

  mem_access_ctrl #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(W3)) dut3 (
    .clk(clk), .rst(rst),
    .fetch_req(d3_fetch_req), .fetch_addr(d3_fetch_addr), .fetch_ack(d3_fetch_ack), .fetch_rdata(d3_fetch_rdata),
    .data_req(d3_data_req), .data_we(1'b0), .data_addr(d3_data_addr), .data_wdata(8'h5A),
    .data_ack(d3_data_ack), .data_rdata(d3_data_rdata),
    .mem_address(d3_mem_address), .mem_read(d3_mem_read), .mem_write(d3_mem_write),
    .mem_data_in(d3_mem_data_in), .mem_data_out(d3_mem_data_out), .busy(d3_busy)
  );

  assign d3_mem_data_out = INIT[d3_mem_address];

  logic [7:0] ref_mem [16];
  exp_t       sb [$];
  logic [7:0] m_fetch = '0;
  logic [7:0] m_data = '0;
  bit         m_data_known = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: bus invariants every cycle, scoreboard pop on each acknowledge.
  exp_t       mon_e;
  int         rd_len = 0, wr_len = 0;
  logic [3:0] p_addr = '0;
  logic [7:0] p_din = '0;
  logic       p_rd = 1'b0, p_wr = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      rd_len = 0; wr_len = 0; p_addr = '0; p_din = '0; p_rd = 1'b0; p_wr = 1'b0;
    end else begin
      chk("strobe_exclusive", 32'(mem_read & mem_write), 0);
      chk("bus_stable", 32'(!(((mem_address != p_addr) || (mem_data_in != p_din)) &&
                              (p_rd || p_wr || mem_read || mem_write))), 1);
      chk("ack_overlap", 32'(fetch_ack & data_ack), 0);
      if (mem_write) wr_len++;
      else if (wr_len != 0) begin chk("write_len", wr_len, W1); wr_len = 0; end
      if (mem_read) rd_len++;
      else if (rd_len != 0) begin chk("read_len", rd_len, W1); rd_len = 0; end
      if (fetch_ack || data_ack) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", sb.size(), 1);
        end else begin
          mon_e = sb.pop_front();
          chk("ack_port", 32'(data_ack), 32'(mon_e.is_data));
          chk("ack_latency", cyc - mon_e.issue, mon_e.lat);
          if (mon_e.is_read) begin
            if (mon_e.is_data) begin m_data = mon_e.exp; m_data_known = mon_e.check_data; end
            else m_fetch = mon_e.exp;
          end
          chk("fetch_rdata", 32'(fetch_rdata), 32'(m_fetch));
          if (m_data_known) chk("data_rdata", 32'(data_rdata), 32'(m_data));
        end
      end
      p_addr = mem_address; p_din = mem_data_in; p_rd = mem_read; p_wr = mem_write;
    end
  end

  task automatic do_single(input bit is_data, input bit we, input logic [3:0] a,
                           input logic [7:0] wd, input bit chkd);
    exp_t e;
    bit   got = 1'b0;
    bit   saw_rd = 1'b0, saw_wr = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 0);
    if (is_data) begin data_req = 1'b1; data_we = we; data_addr = a; data_wdata = wd; end
    else begin fetch_req = 1'b1; fetch_addr = a; end
    e.is_data = is_data; e.is_read = !(is_data && we); e.check_data = chkd;
    e.issue = cyc; e.lat = 3 + W1;
    if (e.is_read) e.exp = ref_mem[a];
    else begin e.exp = '0; ref_mem[a] = wd; end
    sb.push_back(e);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      saw_rd |= mem_read; saw_wr |= mem_write;
      if (is_data ? data_ack : fetch_ack) got = 1'b1;
      else if (i >= 1) begin
        data_addr = 4'($urandom); data_wdata = 8'($urandom);
        data_we = 1'($urandom); fetch_addr = 4'($urandom);
      end
    end
    if (!got) chk("ack_timeout", 32'(got), 1);
    chk("strobe_kind", {30'd0, saw_rd, saw_wr}, e.is_read ? 32'd2 : 32'd1);
    data_req = 1'b0; fetch_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   iss, n, last, rdc;
    bit   got_d, got_f, wr3, din3, acc;
    logic [1:0] kind;

    for (int i = 0; i < 16; i++) ref_mem[i] = INIT[i];
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_mem_address", 32'(mem_address), 0);
    chk("rst_acks", {30'd0, fetch_ack, data_ack}, 0);
    chk("rst_rdata", {16'd0, fetch_rdata, data_rdata}, 0);
    chk("rst_d3_busy", 32'(d3_busy), 0);
    rst = 1'b0;

    do_single(1'b0, 1'b0, 4'd0, 8'h00, 1'b1);
    chk("fetch_addr0", 32'(fetch_rdata), 32'h4C);
    do_single(1'b1, 1'b1, 4'd3, 8'hA5, 1'b1);
    do_single(1'b1, 1'b0, 4'd3, 8'h00, 1'b1);
    chk("load_after_store", 32'(data_rdata), 32'hA5);

    // Simultaneous requests: data must win, fetch follows one full access later.
    @(posedge clk); #1;
    data_req = 1'b1; data_we = 1'b0; data_addr = 4'd12; fetch_req = 1'b1; fetch_addr = 4'd10;
    sb.push_back('{1'b1, 1'b1, 1'b1, ref_mem[12], cyc, 3 + W1});
    sb.push_back('{1'b0, 1'b1, 1'b1, ref_mem[10], cyc, (4 + W1) + (3 + W1)});
    got_d = 1'b0; got_f = 1'b0;
    for (int i = 0; i < 60 && !(got_d && got_f); i++) begin
      @(negedge clk);
      if (data_ack) begin data_req = 1'b0; got_d = 1'b1; end
      if (fetch_ack) begin fetch_req = 1'b0; got_f = 1'b1; end
    end
    data_req = 1'b0; fetch_req = 1'b0;
    chk("simul_both_acked", {30'd0, got_d, got_f}, 3);
    chk("simul_data", 32'(data_rdata), 32'h0E);
    chk("simul_fetch", 32'(fetch_rdata), 32'h08);

    repeat (40) begin
      kind = 2'($urandom_range(0, 2));
      do_single(kind != 2'd0, kind == 2'd2, 4'($urandom), 8'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Slow-strobe instance: latency 6 and one access every 7 cycles.
    @(posedge clk); #1;
    d3_data_req = 1'b1; d3_data_addr = 4'd0; iss = cyc; rdc = 0; got_d = 1'b0; wr3 = 1'b0; din3 = 1'b0;
    for (int i = 0; i < 40 && !got_d; i++) begin
      @(negedge clk);
      if (d3_mem_read) rdc++;
      wr3 |= d3_mem_write; din3 |= (d3_mem_data_in != 8'h00);
      if (d3_data_ack) begin got_d = 1'b1; chk("w3_load_latency", cyc - iss, 6); end
    end
    d3_data_req = 1'b0;
    chk("w3_load_ack", 32'(got_d), 1);
    chk("w3_read_len", rdc, 3);
    chk("w3_load_data", 32'(d3_data_rdata), 32'h4C);
    @(posedge clk); #1;
    d3_fetch_req = 1'b1; d3_fetch_addr = 4'd7; last = cyc; n = 0;
    for (int i = 0; i < 60 && n < 3; i++) begin
      @(negedge clk);
      wr3 |= d3_mem_write; din3 |= (d3_mem_data_in != 8'h00);
      if (d3_fetch_ack) begin
        chk("w3_fetch_period", cyc - last, (n == 0) ? 6 : 7);
        chk("w3_fetch_data", 32'(d3_fetch_rdata), 32'(INIT[7]));
        last = cyc; n++;
      end
    end
    d3_fetch_req = 1'b0;
    chk("w3_fetch_count", n, 3);
    chk("w3_no_write", {30'd0, wr3, din3}, 0);

    // Reset in the middle of a store strobe.
    @(posedge clk); #1;
    data_req = 1'b1; data_we = 1'b1; data_addr = 4'd5; data_wdata = 8'hFF;
    @(posedge clk);
    @(posedge clk);
    #1 chk("strobe_before_rst", 32'(mem_write), 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_write", 32'(mem_write), 0);
    chk("async_rst_read", 32'(mem_read), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_bus", {20'd0, mem_address, mem_data_in}, 0);
    chk("async_rst_acks", {30'd0, fetch_ack, data_ack}, 0);
    chk("async_rst_rdata", {16'd0, fetch_rdata, data_rdata}, 0);
    data_req = 1'b0; m_fetch = '0; m_data = '0; m_data_known = 1'b1; sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    acc = 1'b0;
    repeat (10) begin @(negedge clk); acc |= (data_ack | fetch_ack); end
    chk("no_ack_after_rst", 32'(acc), 0);
    do_single(1'b1, 1'b0, 4'd5, 8'h00, 1'b0);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
